// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   sched_state_e : scheduler FSM state encoding
//   DEFAULT_CPB   : reset bit period (50 MHz clock, 9600 bit/s)
//   MIN_CPB       : smallest legal bit period
//   clamp_cpb()   : maps a requested bit period onto a legal one
package uart_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } sched_state_e;

  localparam logic [31:0] DEFAULT_CPB = 32'd5208;
  localparam logic [31:0] MIN_CPB     = 32'd1;

  // A zero period would stall the transmitter forever, so it is raised to the minimum.
  function automatic logic [31:0] clamp_cpb(input logic [31:0] value);
    return (value < MIN_CPB) ? MIN_CPB : value;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake bus of the UART transmit scheduler.
//   req_valid : per-requester character-available flags
//   req_data  : requester i character at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_ready : one-hot accept pulse; a character moves when valid and ready are both high
// Modports: master = requesters, slave = scheduler.
interface uart_tx_sched_if #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned PAYLOAD_BITS = 8
);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [N_REQ-1:0]              req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   last    : index of the previous grant
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : index of the granted requester
//   any     : at least one request is present
// The search starts at last+1 and wraps modulo N_REQ.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    idx     = 0;
    // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (int'(last) + N_REQ - k) % N_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ requesters.
//   clk, resetn    : clock, synchronous active-low reset
//   req_bus        : requester handshake (valid/data in, one-hot ready out)
//   cfg_we/wdata   : bit-period write; deferred while a frame is in flight
//   cycles_per_bit : registered bit period for the transmitter
//   tx_en, tx_data : one-cycle send strobe and registered character
//   tx_busy        : transmitter busy flag
//   grant_id       : index of the most recent grant
//   sched_busy     : scheduler is not idle
module uart_tx_sched #(
  parameter  int unsigned N_REQ        = 4,
  parameter  int unsigned PAYLOAD_BITS = 8,
  parameter  logic [31:0] DEFAULT_CPB  = uart_sched_pkg::DEFAULT_CPB,
  localparam int unsigned ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  uart_tx_sched_if.slave          req_bus,
  input  logic                    cfg_we,
  input  logic [31:0]             cfg_wdata,
  output logic [31:0]             cycles_per_bit,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         grant_id,
  output logic                    sched_busy
);

  import uart_sched_pkg::*;

  sched_state_e state_q;
  logic         cfg_pend_q;
  logic [31:0]  cfg_pend_val_q;

  logic [N_REQ-1:0]        arb_gnt;
  logic [ID_W-1:0]         arb_idx;
  logic                    arb_any;
  logic                    idle_free;
  logic                    grant_fire;
  logic [PAYLOAD_BITS-1:0] sel_data;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req     (req_bus.req_valid),
    .last    (grant_id),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    idle_free  = (state_q == StIdle) && !tx_busy;
    // A configuration write (new or pending) takes the idle slot instead of a grant.
    grant_fire = idle_free && !cfg_we && !cfg_pend_q && arb_any;
    req_bus.req_ready = (resetn && grant_fire) ? arb_gnt : '0;
    sel_data   = req_bus.req_data[int'(arb_idx) * PAYLOAD_BITS +: PAYLOAD_BITS];
    sched_busy = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= StIdle;
      tx_en          <= 1'b0;
      tx_data        <= '0;
      grant_id       <= ID_W'(N_REQ - 1);
      cycles_per_bit <= DEFAULT_CPB;
      cfg_pend_q     <= 1'b0;
      cfg_pend_val_q <= '0;
    end else begin
      tx_en <= 1'b0;

      // Bit period only moves while both scheduler and transmitter are quiet.
      if (cfg_we) begin
        if (idle_free) begin
          cycles_per_bit <= clamp_cpb(cfg_wdata);
          cfg_pend_q     <= 1'b0;
        end else begin
          cfg_pend_q     <= 1'b1;
          cfg_pend_val_q <= clamp_cpb(cfg_wdata);
        end
      end else if (idle_free && cfg_pend_q) begin
        cycles_per_bit <= cfg_pend_val_q;
        cfg_pend_q     <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (grant_fire) begin
            state_q  <= StIssue;
            tx_en    <= 1'b1;
            tx_data  <= sel_data;
            grant_id <= arb_idx;
          end
        end
        StIssue: begin
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (!tx_busy) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed steps plus randomized traffic
// scored against a round-robin reference model and a simple transmitter model.
module tb_uart_tx_sched;

  localparam int unsigned N     = 4;
  localparam int unsigned PB    = 8;
  localparam int          FRAME = 40;  // 10 bits at 4 cycles per bit

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_we;
  logic [31:0] cfg_wdata;
  logic [31:0] cycles_per_bit;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        sched_busy;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N), .PAYLOAD_BITS(PB)) bus ();

  uart_tx_sched #(
    .N_REQ        (N),
    .PAYLOAD_BITS (PB),
    .DEFAULT_CPB  (32'd5208)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_bus        (bus),
    .cfg_we         (cfg_we),
    .cfg_wdata      (cfg_wdata),
    .cycles_per_bit (cycles_per_bit),
    .tx_en          (tx_en),
    .tx_data        (tx_data),
    .tx_busy        (tx_busy),
    .grant_id       (grant_id),
    .sched_busy     (sched_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transmitter model state
  bit auto_tx   = 1'b0;
  bit tx_pend   = 1'b0;
  int busy_left = 0;

  // Reference model state
  logic [7:0] chr_q [N][$];
  logic [7:0] exp_tx [$];
  int         grant_log [$];
  int         model_last;
  int         n_tx_en;
  int         n_grants;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and run the transmitter model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_tx) begin
      if (tx_pend) begin
        tx_busy   = 1'b1;
        busy_left = FRAME;
        tx_pend   = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (tx_en) tx_pend = 1'b1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input int i, input logic v, input logic [7:0] d);
    bus.req_valid[i]          = v;
    bus.req_data[i*PB +: PB]  = d;
  endtask

  function automatic int pending_chars();
    int s = 0;
    for (int i = 0; i < N; i++) s += chr_q[i].size();
    return s;
  endfunction

  // Randomized traffic scored against the round-robin rule.
  task automatic traffic(input int cycles, input bit keep_full, input int hide_pct);
    logic [N-1:0] vld;
    bit           prev_en;
    int           g;
    int           budget;
    prev_en = 1'b0;
    n_tx_en = 0;
    n_grants = 0;
    budget  = cycles + 3000;
    for (int c = 0; c < budget; c++) begin
      if (c >= cycles && pending_chars() == 0 && exp_tx.size() == 0 && !sched_busy &&
          !tx_busy && !tx_pend) break;
      tick();
      check("tx_en_one_cycle", 32'(tx_en & prev_en), 0);
      prev_en = tx_en;
      if (tx_en) begin
        n_tx_en++;
        if (exp_tx.size() == 0) begin
          check("tx_en_unexpected", 32'(tx_en), 0);
        end else begin
          check("tx_data_order", 32'(tx_data), 32'(exp_tx.pop_front()));
          check("grant_id_after_grant", 32'(grant_id), 32'(model_last));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (keep_full && c < cycles && chr_q[i].size() == 0) chr_q[i].push_back(8'($urandom));
        vld[i] = (chr_q[i].size() > 0) && (hide_pct == 0 || $urandom_range(99) >= hide_pct);
        drive_req(i, vld[i], (chr_q[i].size() > 0) ? chr_q[i][0] : 8'($urandom));
      end
      settle();
      check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      if (sched_busy) check("ready_low_when_busy", 32'(bus.req_ready), 0);
      if (bus.req_ready != '0) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (model_last + k) % N;
          if (g < 0 && vld[idx]) g = idx;
        end
        if (g < 0) begin
          check("rr_grant_without_valid", 32'(bus.req_ready), 0);
        end else begin
          check("rr_grant", 32'(bus.req_ready), 32'(1 << g));
          model_last = g;
          n_grants++;
          grant_log.push_back(g);
          exp_tx.push_back(chr_q[g].pop_front());
        end
      end
    end
    bus.req_valid = '0;
    check("traffic_drained", 32'(pending_chars() + exp_tx.size()), 0);
    check("one_tx_en_per_grant", 32'(n_tx_en), 32'(n_grants));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn        = 1'b0;
    cfg_we        = 1'b0;
    cfg_wdata     = '0;
    tx_busy       = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset values, with requests present
    repeat (3) tick();
    bus.req_valid = '1;
    bus.req_data  = {N{8'h5A}};
    settle();
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_grant_id", 32'(grant_id), 3);
    check("rst_cpb", cycles_per_bit, 32'd5208);
    check("rst_sched_busy", 32'(sched_busy), 0);
    resetn        = 1'b1;
    bus.req_valid = '0;

    // Requester 2 alone
    tick();
    drive_req(2, 1'b1, 8'h41);
    settle();
    check("r2_ready", 32'(bus.req_ready), 32'h4);
    check("r2_idle", 32'(sched_busy), 0);
    tick();
    bus.req_valid = '0;
    settle();
    check("r2_tx_en", 32'(tx_en), 1);
    check("r2_tx_data", 32'(tx_data), 32'h41);
    check("r2_grant_id", 32'(grant_id), 2);
    check("r2_ready_after", 32'(bus.req_ready), 0);
    check("r2_busy", 32'(sched_busy), 1);
    tick();
    check("r2_tx_en_drop", 32'(tx_en), 0);
    tx_busy = 1'b1;
    tick();
    check("r2_wait_done_busy", 32'(sched_busy), 1);
    tx_busy = 1'b0;
    tick();
    check("r2_back_idle", 32'(sched_busy), 0);

    // Config write of zero in idle takes priority over a grant
    cfg_we    = 1'b1;
    cfg_wdata = 32'd0;
    drive_req(0, 1'b1, 8'h33);
    settle();
    check("cfg_priority_no_grant", 32'(bus.req_ready), 0);
    tick();
    cfg_we        = 1'b0;
    bus.req_valid = '0;
    settle();
    check("cfg_zero_is_one", cycles_per_bit, 32'd1);
    check("cfg_no_issue", 32'(sched_busy), 0);

    // Reset back to a known arbitration point
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("rst2_cpb", cycles_per_bit, 32'd5208);
    check("rst2_grant_id", 32'(grant_id), 3);

    // All four requesters continuously valid
    auto_tx    = 1'b1;
    model_last = 3;
    grant_log.delete();
    traffic(200, 1'b1, 0);
    check("rr_log_len", 32'(grant_log.size() >= 5), 1);
    if (grant_log.size() >= 5) begin
      check("rr_order_0", 32'(grant_log[0]), 0);
      check("rr_order_1", 32'(grant_log[1]), 1);
      check("rr_order_2", 32'(grant_log[2]), 2);
      check("rr_order_3", 32'(grant_log[3]), 3);
      check("rr_order_4", 32'(grant_log[4]), 0);
    end

    // Random sparse traffic with requesters flickering their valid
    for (int i = 0; i < N; i++) begin
      int n;
      n = $urandom_range(3);
      for (int j = 0; j < n; j++) chr_q[i].push_back(8'($urandom));
    end
    traffic(0, 1'b0, 30);
    auto_tx   = 1'b0;
    tx_pend   = 1'b0;
    busy_left = 0;
    tx_busy   = 1'b0;

    // Deferred config write during a frame, last write wins
    tick();
    drive_req(1, 1'b1, 8'h77);
    settle();
    check("c1_ready", 32'(bus.req_ready), 32'h2);
    tick();
    drive_req(1, 1'b1, 8'h78);
    settle();
    check("c1_tx_en", 32'(tx_en), 1);
    check("c1_tx_data", 32'(tx_data), 32'h77);
    tick();
    tx_busy = 1'b1;
    check("c1_data_stable_wb", 32'(tx_data), 32'h77);
    tick();
    cfg_we    = 1'b1;
    cfg_wdata = 32'h22;
    settle();
    check("c1_no_ready_wd", 32'(bus.req_ready), 0);
    tick();
    cfg_wdata = 32'h10;
    check("c1_cpb_hold_0", cycles_per_bit, 32'd5208);
    tick();
    cfg_we = 1'b0;
    check("c1_cpb_hold_1", cycles_per_bit, 32'd5208);
    check("c1_data_stable_wd", 32'(tx_data), 32'h77);
    tx_busy = 1'b0;
    tick();
    settle();
    check("c1_first_idle", 32'(sched_busy), 0);
    check("c1_no_grant_on_apply", 32'(bus.req_ready), 0);
    tick();
    settle();
    check("c1_cpb_applied", cycles_per_bit, 32'h10);
    check("c1_second_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("c1_second_tx_data", 32'(tx_data), 32'h78);
    check("c1_second_tx_en", 32'(tx_en), 1);

    // Reset pulse in WAIT_BUSY while the transmitter is still busy
    tick();
    tx_busy = 1'b1;
    resetn  = 1'b0;
    tick();
    resetn = 1'b1;
    drive_req(0, 1'b1, 8'h55);
    settle();
    check("mr_sched_busy", 32'(sched_busy), 0);
    check("mr_tx_en", 32'(tx_en), 0);
    check("mr_cpb", cycles_per_bit, 32'd5208);
    check("mr_grant_id", 32'(grant_id), 3);
    check("mr_no_ready_busy", 32'(bus.req_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      check("mr_wait_tx_busy", 32'(bus.req_ready), 0);
      check("mr_no_tx_en", 32'(tx_en), 0);
    end
    tick();
    tx_busy = 1'b0;
    settle();
    check("mr_grant_after_idle", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    check("mr_tx_en", 32'(tx_en), 1);
    check("mr_tx_data", 32'(tx_data), 32'h55);
    check("mr_grant_id_0", 32'(grant_id), 0);

    // Short valid pulse from requester 1 while busy must not transmit
    tick();
    tx_busy = 1'b1;
    drive_req(1, 1'b1, 8'h99);
    settle();
    check("pulse_no_ready", 32'(bus.req_ready), 0);
    tick();
    bus.req_valid = '0;
    tick();
    tx_busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      settle();
      check("pulse_idle", 32'(sched_busy), 0);
      check("pulse_no_tx_en", 32'(tx_en), 0);
      check("pulse_no_ready_idle", 32'(bus.req_ready), 0);
    end
    check("pulse_last_grant", 32'(grant_id), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter PAYLOAD_BITS, default 8: character width.
REQ-003 Parameter DEFAULT_CPB, default 5208: reset value of cycles_per_bit (50 MHz clock, 9600 bit/s).
REQ-004 Clock and reset SHALL be: reset resetn, synchronous, active-low; clock clk.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 resetn  in  1  synchronous active-low reset.
REQ-007 req_valid  in  N_REQ  per-requester character-available flag.
REQ-008 req_data  in  N_REQ*PAYLOAD_BITS  requester i data at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-009 req_ready  out  N_REQ  one-hot accept pulse; a character transfers when valid and ready are both high.
REQ-010 cfg_we  in  1  write strobe for the bit-period register.
REQ-011 cfg_wdata  in  32  new cycles_per_bit value.
REQ-012 cycles_per_bit  out  32  registered bit period, driven to the transmitter.
REQ-013 tx_en  out  1  single-cycle send strobe to the transmitter.
REQ-014 tx_data  out  PAYLOAD_BITS  registered character to the transmitter.
REQ-015 tx_busy  in  1  transmitter busy flag; goes high the cycle after tx_en and stays high until the stop bit ends.
REQ-016 grant_id  out  clog2(N_REQ)  index of the most recently granted requester.
REQ-017 sched_busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> ISSUE SHALL occur when any req_valid is high, tx_busy is low and no configuration write is pending.
  - In that same cycle, req_ready[g] pulses.
  - req_data[g] is latched into tx_data.
  - grant_id <= g.
REQ-020 The grant g SHALL be round-robin: the first valid index searching upward from grant_id+1, wrapping modulo N_REQ.
REQ-021 ISSUE SHALL assert tx_en for exactly one cycle, then move to WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL move to WAIT_DONE on the first cycle tx_busy is high.
REQ-023 WAIT_DONE SHALL move to IDLE on the first cycle tx_busy is low.
REQ-024 Minimum spacing between successive tx_en pulses: ISSUE, WAIT_BUSY, frame time, WAIT_DONE, IDLE.
REQ-025 req_ready SHALL never be high outside IDLE, and never more than one bit at a time.
REQ-026 tx_data SHALL stay stable from the grant cycle until the return to IDLE.
REQ-027 A requester dropping req_valid while not granted SHALL lose nothing and cause no grant.
REQ-028 cfg_we in IDLE with tx_busy low SHALL update cycles_per_bit on the next edge.
  - In that cycle, cfg_we has priority over a grant and no grant is issued.
REQ-029 cfg_we at any other time SHALL be held in a pending register and applied in the first IDLE cycle with tx_busy low.
  - No grant is issued in that cycle.
  - A later cfg_we overwrites the pending value (last write wins).
REQ-030 A cfg_wdata of 0 SHALL be stored as 1.
REQ-031 cycles_per_bit SHALL never change while sched_busy or tx_busy is high.

Reset
REQ-032 While resetn is low, at each edge the block SHALL:
  - set state IDLE;
  - drive tx_en 0, tx_data 0, req_ready 0;
  - set grant_id N_REQ-1, so requester 0 has first priority;
  - set cycles_per_bit to DEFAULT_CPB;
  - clear the pending configuration write.
REQ-033 Reset asserted mid-frame SHALL abort the sequence immediately.
  - After release, the FSM waits in IDLE for tx_busy low before granting.

Structure
REQ-034 A package uart_sched_pkg SHALL hold the FSM state encoding, DEFAULT_CPB and the minimum-CPB constant (1).
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter.
  - Inputs: request vector and last grant.
  - Outputs: one-hot grant, grant index and any-request flag.
  - Purely combinational.

Verification
REQ-036 Bench: requester 2 valid alone, data 0x41, after reset -> req_ready=0100 once; tx_en one cycle later with tx_data 0x41; grant_id=2.
REQ-037 Bench: all four valid continuously with a transmitter model of CPB=4 -> grants in order 0,1,2,3,0; exactly one tx_en per frame.
REQ-038 Bench: cfg_we with 0x10 during WAIT_DONE -> cycles_per_bit unchanged until IDLE; becomes 0x10 in the first IDLE cycle; no grant in that cycle.
REQ-039 Bench: cfg_we with 0 while idle -> cycles_per_bit reads 1 on the next cycle.
REQ-040 Bench: resetn low for one cycle during WAIT_BUSY -> state IDLE, tx_en 0, cycles_per_bit=5208, grant_id=3; no grant until tx_busy is low.
REQ-041 Bench: req_valid[1] pulses high for one cycle while sched_busy -> no req_ready[1], and no transmission for that requester.
